// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO between instruction memory and the IF/ID register.
// Optional same-cycle response bypass on an empty queue: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [63:0]      imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_instr,
  input  logic             redirect,
  input  logic [63:0]      redirect_pc,
  input  logic             deq_ready,
  output logic             deq_valid,
  output logic [31:0]      deq_instr,
  output logic [63:0]      deq_pc_plus4,
  output logic [PTR_W:0]   occupancy
);

  localparam logic [PTR_W+1:0] CREDITS = (PTR_W+2)'(DEPTH);

  logic [63:0]      fetch_pc;
  logic [63:0]      req_pc;
  logic             req_epoch;
  logic             epoch;
  logic             inflight;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic [31:0] instr_mem [DEPTH];
  logic [63:0] pc4_mem   [DEPTH];

  logic             stored_valid;
  logic             rsp_accept;
  logic             bypass_fire;
  logic             deq_fire;
  logic             enq;
  logic [63:0]      rsp_pc4;
  logic [PTR_W+1:0] credits_used;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];
  assign occupancy      = count;

  always_comb begin
    stored_valid = (count != '0);
    credits_used = {1'b0, count} + {{(PTR_W+1){1'b0}}, inflight};
    imem_req     = reset && !redirect && (credits_used < CREDITS);
    imem_addr    = imem_req ? fetch_pc : '0;

    // A response is only meaningful if it answers a request from the current stream.
    rsp_accept   = reset && !redirect && imem_rsp_valid && inflight && (req_epoch == epoch);
    rsp_pc4      = req_pc + 64'd4;

`ifdef FETCH_QUEUE_BYPASS_EN
    deq_valid    = stored_valid || rsp_accept;
    bypass_fire  = !stored_valid && rsp_accept && deq_ready;
`else
    deq_valid    = stored_valid;
    bypass_fire  = 1'b0;
`endif

    deq_fire     = stored_valid && deq_ready;
    enq          = rsp_accept && !bypass_fire;

    deq_instr    = '0;
    deq_pc_plus4 = '0;
    if (stored_valid) begin
      deq_instr    = instr_mem[rd_ptr];
      deq_pc_plus4 = pc4_mem[rd_ptr];
    end else if (deq_valid) begin
      deq_instr    = imem_rsp_instr;
      deq_pc_plus4 = rsp_pc4;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc  <= '0;
      req_pc    <= '0;
      req_epoch <= 1'b0;
      epoch     <= 1'b0;
      inflight  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else if (redirect) begin
      fetch_pc  <= {redirect_pc[63:2], 2'b00};
      epoch     <= ~epoch;
      inflight  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      // Memory answers exactly one cycle later, so in-flight is just last cycle's issue.
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc  <= fetch_pc + 64'd4;
        req_pc    <= fetch_pc;
        req_epoch <= epoch;
      end
      if (enq)      wr_ptr <= wr_ptr + 1'b1;
      if (deq_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      instr_mem[wr_ptr] <= imem_rsp_instr;
      pc4_mem[wr_ptr]   <= rsp_pc4;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the prefetch buffer.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int VW    = PTR_W + 163;

  logic             clk = 1'b0;
  logic             reset;
  logic             imem_req;
  logic [63:0]      imem_addr;
  logic             imem_rsp_valid;
  logic [31:0]      imem_rsp_instr;
  logic             redirect;
  logic [63:0]      redirect_pc;
  logic             deq_ready;
  logic             deq_valid;
  logic [31:0]      deq_instr;
  logic [63:0]      deq_pc_plus4;
  logic [PTR_W:0]   occupancy;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_instr (imem_rsp_instr),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .deq_ready      (deq_ready),
    .deq_valid      (deq_valid),
    .deq_instr      (deq_instr),
    .deq_pc_plus4   (deq_pc_plus4),
    .occupancy      (occupancy)
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc4;
  } entry_t;

  // Reference model: buffered entries, next fetch PC, outstanding request.
  entry_t      q[$];
  logic [63:0] m_pc;
  logic [63:0] m_pend_pc;
  bit          m_pend;
  bit          rsp_ok;

  bit             exp_req;
  logic [63:0]    exp_addr;
  bit             exp_dv;
  logic [31:0]    exp_instr;
  logic [63:0]    exp_pc4;
  logic [PTR_W:0] exp_occ;

  int n_cmp  = 0;
  int n_fail = 0;
  bit rand_instr = 1'b0;
  bit inject     = 1'b0;

  function automatic void model_eval();
    rsp_ok    = m_pend && (reset === 1'b1) && (redirect === 1'b0);
    exp_req   = (reset === 1'b1) && (redirect === 1'b0) && ((q.size() + int'(m_pend)) < DEPTH);
    exp_addr  = exp_req ? m_pc : 64'd0;
    exp_occ   = (PTR_W+1)'(q.size());
    exp_dv    = 1'b0;
    exp_instr = '0;
    exp_pc4   = '0;
    if (q.size() != 0) begin
      exp_dv    = 1'b1;
      exp_instr = q[0].instr;
      exp_pc4   = q[0].pc4;
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    else if (rsp_ok) begin
      exp_dv    = 1'b1;
      exp_instr = imem_rsp_instr;
      exp_pc4   = m_pend_pc + 64'd4;
    end
`endif
  endfunction

  function automatic void model_update();
    bit taken_by_bypass = 1'b0;
    if (reset !== 1'b1) begin
      q.delete();
      m_pc      = '0;
      m_pend    = 1'b0;
      m_pend_pc = '0;
    end else if (redirect === 1'b1) begin
      q.delete();
      m_pc   = {redirect_pc[63:2], 2'b00};
      m_pend = 1'b0;
    end else begin
      if (q.size() != 0) begin
        if (deq_ready) void'(q.pop_front());
      end
`ifdef FETCH_QUEUE_BYPASS_EN
      else if (rsp_ok && deq_ready) taken_by_bypass = 1'b1;
`endif
      if (rsp_ok && !taken_by_bypass)
        q.push_back('{instr: imem_rsp_instr, pc4: m_pend_pc + 64'd4});
      m_pend = exp_req;
      if (exp_req) begin
        m_pend_pc = m_pc;
        m_pc      = m_pc + 64'd4;
      end
    end
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {imem_req, imem_addr, deq_valid, deq_instr, deq_pc_plus4, occupancy};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {exp_req, exp_addr, exp_dv, exp_instr, exp_pc4, exp_occ};
  endfunction

  // Advance one clock; the instruction memory answers every request one cycle later.
  task automatic tick();
    bit          r;
    logic [63:0] a;
    #1;
    model_eval();
    r = imem_req;
    a = imem_addr;
    @(posedge clk);
    model_update();
    @(negedge clk);
    imem_rsp_valid = r | inject;
    inject         = 1'b0;
    imem_rsp_instr = rand_instr ? $urandom : (a[31:0] + 32'h1000);
  endtask

  task automatic apply_reset();
    reset    = 1'b0;
    redirect = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; redirect = 1'b1; redirect_pc = 64'h55; deq_ready = 1'b1;
    tick(); tick(); tick();
    #1; model_eval();
    n_cmp++;
    if (dut_vec() !== {VW{1'b0}}) begin
      n_fail++; $display("FAIL reset_outputs got %h want 0", dut_vec());
    end
    redirect = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    apply_reset();
    reset = 1'b1; deq_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1; model_eval();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL stream_model cyc%0d got %h want %h", i, dut_vec(), exp_vec());
      end
      if (i >= 2) begin
        logic [31:0] ei;
        logic [63:0] ep;
        ei = 32'h1000 + 32'(4 * (i - 2));
        ep = 64'(4 * (i - 1));
        n_cmp++;
        if ({deq_valid, deq_instr, deq_pc_plus4} !== {1'b1, ei, ep}) begin
          n_fail++;
          $display("FAIL stream_seq cyc%0d got v=%b i=%h p=%h want v=1 i=%h p=%h",
                   i, deq_valid, deq_instr, deq_pc_plus4, ei, ep);
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [63:0] addrs[$];
    logic [63:0] first_addr;
    bit          seen;
    apply_reset();
    reset = 1'b1; deq_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1; model_eval();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL stall_model cyc%0d got %h want %h", i, dut_vec(), exp_vec());
      end
      if (imem_req) addrs.push_back(imem_addr);
      tick();
    end
    n_cmp++;
    if (addrs.size() !== DEPTH || occupancy !== (PTR_W+1)'(DEPTH)) begin
      n_fail++; $display("FAIL stall_fill got reqs=%0d occ=%0d want reqs=%0d occ=%0d",
                         addrs.size(), occupancy, DEPTH, DEPTH);
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        n_cmp++;
        if (addrs[k] !== 64'(4 * k)) begin
          n_fail++; $display("FAIL stall_addr%0d got %h want %h", k, addrs[k], 64'(4 * k));
        end
      end
    end
    deq_ready  = 1'b1;
    seen       = 1'b0;
    first_addr = '0;
    for (int i = 0; i < 10; i++) begin
      #1; model_eval();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL drain_model cyc%0d got %h want %h", i, dut_vec(), exp_vec());
      end
      if (imem_req && !seen) begin seen = 1'b1; first_addr = imem_addr; end
      tick();
    end
    n_cmp++;
    if (!seen || first_addr !== 64'h10) begin
      n_fail++; $display("FAIL drain_resume got seen=%b addr=%h want addr=10", seen, first_addr);
    end
  endtask

  task automatic test_redirect();
    bit found;
    apply_reset();
    reset = 1'b1; deq_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    redirect = 1'b1; redirect_pc = 64'h103;
    #1; model_eval();
    n_cmp++;
    if (dut_vec() !== exp_vec() || occupancy !== (PTR_W+1)'(3)) begin
      n_fail++; $display("FAIL redir_setup got %h occ=%0d want %h occ=3", dut_vec(), occupancy, exp_vec());
    end
    tick();
    redirect = 1'b0;
    #1; model_eval();
    n_cmp++;
    if ({deq_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 64'h100}) begin
      n_fail++; $display("FAIL redir_next got dv=%b req=%b addr=%h want dv=0 req=1 addr=100",
                         deq_valid, imem_req, imem_addr);
    end
    deq_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      #1; model_eval();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL redir_model cyc%0d got %h want %h", i, dut_vec(), exp_vec());
      end
      if (deq_valid) begin
        found = 1'b1;
        n_cmp++;
        if ({deq_instr, deq_pc_plus4} !== {32'h1100, 64'h104}) begin
          n_fail++; $display("FAIL redir_first got i=%h p=%h want i=1100 p=104", deq_instr, deq_pc_plus4);
        end
      end
      tick();
    end
    if (!found) begin
      n_cmp++; n_fail++; $display("FAIL redir_timeout got no deq_valid want deq_valid within 6 cycles");
    end
  endtask

  task automatic test_redirect_deq();
    int old_seen;
    apply_reset();
    reset = 1'b1; deq_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    redirect = 1'b1; redirect_pc = 64'h2000;
    #1; model_eval();
    n_cmp++;
    if (dut_vec() !== exp_vec() || deq_valid !== 1'b1) begin
      n_fail++; $display("FAIL rdq_head got %h want %h", dut_vec(), exp_vec());
    end
    tick();
    redirect = 1'b0;
    old_seen = 0;
    for (int i = 0; i < 10; i++) begin
      #1; model_eval();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rdq_model cyc%0d got %h want %h", i, dut_vec(), exp_vec());
      end
      if (deq_valid && deq_pc_plus4 < 64'h2004) old_seen++;
      tick();
    end
    n_cmp++;
    if (old_seen !== 0) begin
      n_fail++; $display("FAIL rdq_stale got %0d old entries want 0", old_seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] pcs [3];
    pcs[0] = 64'h300; pcs[1] = 64'h400; pcs[2] = 64'h505;
    apply_reset();
    reset = 1'b1; deq_ready = 1'b1;
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      redirect = 1'b1; redirect_pc = pcs[k];
      tick();
    end
    redirect = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1; model_eval();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL b2b_model cyc%0d got %h want %h", i, dut_vec(), exp_vec());
      end
      if (i == 0) begin
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 64'h504}) begin
          n_fail++; $display("FAIL b2b_restart got req=%b addr=%h want req=1 addr=504", imem_req, imem_addr);
        end
      end
      if (deq_valid && deq_pc_plus4 < 64'h508) begin
        n_cmp++; n_fail++;
        $display("FAIL b2b_stale got pc4=%h want >= 508", deq_pc_plus4);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    reset = 1'b1; deq_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    reset = 1'b0; redirect = 1'b1; redirect_pc = 64'h777;
    tick();
    redirect = 1'b0;
    #1; model_eval();
    n_cmp++;
    if (dut_vec() !== {VW{1'b0}}) begin
      n_fail++; $display("FAIL rstmid_zero got %h want 0", dut_vec());
    end
    inject = 1'b1;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1; model_eval();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL rstmid_model cyc%0d got %h want %h", i, dut_vec(), exp_vec());
      end
      if (i == 0) begin
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, 64'h0}) begin
          n_fail++; $display("FAIL rstmid_restart got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr);
        end
      end
      if (i == 1) begin
        n_cmp++;
        if ({deq_valid, occupancy} !== {1'b0, {(PTR_W+1){1'b0}}}) begin
          n_fail++; $display("FAIL rstmid_drop got dv=%b occ=%0d want dv=0 occ=0", deq_valid, occupancy);
        end
      end
      tick();
    end
  endtask

  task automatic test_bypass();
    apply_reset();
    reset = 1'b1; deq_ready = 1'b1; redirect = 1'b1; redirect_pc = 64'h20;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1; model_eval();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL bypass_model cyc%0d got %h want %h", i, dut_vec(), exp_vec());
      end
`ifdef FETCH_QUEUE_BYPASS_EN
      if (i == 1) begin
        n_cmp++;
        if ({deq_valid, deq_pc_plus4, occupancy} !== {1'b1, 64'h24, {(PTR_W+1){1'b0}}}) begin
          n_fail++; $display("FAIL bypass_same got dv=%b p=%h occ=%0d want dv=1 p=24 occ=0",
                             deq_valid, deq_pc_plus4, occupancy);
        end
      end
`else
      if (i == 2) begin
        n_cmp++;
        if ({deq_valid, deq_pc_plus4} !== {1'b1, 64'h24}) begin
          n_fail++; $display("FAIL bypass_off got dv=%b p=%h want dv=1 p=24", deq_valid, deq_pc_plus4);
        end
      end
`endif
      tick();
    end
  endtask

  task automatic test_random();
    apply_reset();
    reset = 1'b1;
    rand_instr = 1'b1;
    for (int i = 0; i < 800; i++) begin
      reset     = ($urandom_range(0, 99) != 0);
      redirect  = ($urandom_range(0, 15) == 0);
      deq_ready = ($urandom_range(0, 3) != 0);
      redirect_pc = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      #1; model_eval();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random_model cyc%0d got %h want %h", i, dut_vec(), exp_vec());
      end
      tick();
    end
    rand_instr = 1'b0;
  endtask

  initial begin
    reset = 1'b0; redirect = 1'b0; redirect_pc = '0; deq_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_instr = '0;
    q.delete(); m_pc = '0; m_pend = 1'b0; m_pend_pc = '0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_deq();
    test_back_to_back();
    test_reset_mid();
    test_bypass();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch buffer between instruction memory and the IF/ID pipeline register.
- Issues sequential fetch requests ahead of decode and buffers returned instructions with their PC+4 in a small circular FIFO.
- Lets decode stalls (hazard unit) absorb without re-fetching.
- Flushes everything and restarts fetch on a branch redirect from the MEM stage.

Parameters:
- DEPTH, 4, number of buffered instruction entries; power of two, 2..16.
- PTR_W, $clog2(DEPTH), read/write pointer width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk)
- imem_req  output  1  fetch request valid this cycle
- imem_addr  output  64  fetch address (word aligned)
- imem_rsp_valid  input  1  response valid; always exactly 1 cycle after a request
- imem_rsp_instr  input  32  instruction for the request issued the previous cycle
- redirect  input  1  branch taken; flush and restart
- redirect_pc  input  64  new fetch PC; bits [1:0] ignored and treated as 0
- deq_ready  input  1  IF/ID can accept (driven by not_stall)
- deq_valid  output  1  head entry valid
- deq_instr  output  32  head instruction
- deq_pc_plus4  output  64  head instruction address + 4
- occupancy  output  PTR_W+1  entries currently held (0..DEPTH)

Behaviour:
- Reset (reset==0 at posedge): fetch_pc=0, wr_ptr=rd_ptr=0, count=0, inflight=0, epoch=0. Outputs imem_req=0, imem_addr=0, deq_valid=0, deq_instr=0, deq_pc_plus4=0, occupancy=0. Reset overrides redirect, in-flight responses and dequeue. A response arriving in the cycle after reset deasserts is discarded.
- Credit rule: imem_req=1 iff count + inflight < DEPTH, reset deasserted, and redirect=0.
- Fetch address: imem_addr=fetch_pc whenever imem_req=1. On issue, fetch_pc += 4 (64-bit wrap, no overflow flag); inflight<=1; the request's PC and current epoch are recorded.
- Enqueue: on imem_rsp_valid with recorded epoch == current epoch, write {instr, pc+4} at wr_ptr, wr_ptr+1 mod DEPTH. Stale-epoch responses are dropped silently.
- Dequeue: deq_valid = (count != 0). On deq_valid & deq_ready, rd_ptr+1 mod DEPTH. Outputs show the head entry combinationally from storage.
- count update: +1 on enqueue, -1 on dequeue, unchanged when both occur. Credits guarantee no enqueue when full, so an overflow condition never exists.
- Redirect (registered effect at posedge):
  - count, rd_ptr, wr_ptr <= 0; fetch_pc <= {redirect_pc[63:2], 2'b00}; epoch toggles; no request issued in the redirect cycle.
  - A dequeue handshake in the redirect cycle is still honoured: the head is consumed by IF/ID that cycle.
  - deq_valid=0 in the following cycle.
  - First new request issues in the cycle after redirect. Its instruction appears at deq_valid 2 cycles after the redirect edge.
- Back-to-back redirects: each restarts from its own redirect_pc; only the last one's stream is enqueued.
- Steady state: with deq_ready held 1, throughput is one instruction per cycle after 2-cycle initial fill latency.

Optional Feature:
- Macro FETCH_QUEUE_BYPASS_EN.
- Defined: when count==0 and a current-epoch response arrives, deq_valid=1 in the same cycle with deq_instr=imem_rsp_instr and deq_pc_plus4=that response's pc+4. If deq_ready=1, the entry is consumed and not written to storage; otherwise it is enqueued normally. Redirect-to-deq latency drops from 2 to 1 cycle.
- Not defined: every response is written to storage first, so deq_valid rises the cycle after enqueue.

Test Plan:
- Release reset, deq_ready=1, imem returns instr = addr+0x1000 -> requests at 0,4,8,... one per cycle; deq stream 0x1000,0x1004,... with deq_pc_plus4 4,8,...; no gaps after fill.
- Hold deq_ready=0 from reset, DEPTH=4 -> exactly 4 requests (0..0xC); imem_req then stays 0; occupancy=4. Raise deq_ready -> entries drain in order, fetch resumes at 0x10.
- Queue holding 3 entries, one request in flight; pulse redirect with redirect_pc=0x103 -> in-flight response dropped; deq_valid=0 next cycle; next imem_addr=0x100; first deq_pc_plus4=0x104.
- Redirect=1 in the same cycle as deq_valid & deq_ready -> head consumed exactly once; no old-stream entry after flush.
- Assert reset=0 mid-stream with redirect=1 and a response arriving -> next cycle all outputs 0, occupancy=0; fetch restarts at 0.
- With FETCH_QUEUE_BYPASS_EN and an empty queue, response for addr 0x20 with deq_ready=1 -> deq_valid same cycle, deq_pc_plus4=0x24, occupancy stays 0.
